// File: rtl/sti_rx_pack.sv
// sti_rx_pack: deserialises frames from an upstream serial transmitter and
// packs each one into a right-justified 32-bit word. Completed frames go into
// a 2-entry FIFO together with their received length and an error flag.
//
// Ports
//   clk        : single clock, rising-edge state updates
//   reset      : asynchronous, active-low; clears all state
//   so_data    : serial data bit
//   so_valid   : high while so_data carries a frame bit (one bit per cycle)
//   cfg_msb    : 1 = MSB-first frame, 0 = LSB-first frame (sampled at frame start)
//   cfg_length : expected length 00=8, 01=16, 10=24, 11=32 (sampled at frame start)
//   word_ready : downstream accepts the head word when high with word_valid
//   word_data  : head word data, zero when word_valid is low
//   word_len   : head word bit count (1..32, 33 = overlength), zero when empty
//   word_err   : head word length differed from the expected length
//   word_valid : FIFO holds at least one word
//   overflow   : sticky; a completed frame was dropped on a full FIFO
//   frame_cnt  : frames pushed into the FIFO, wraps at 256
module sti_rx_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        so_data,
    input  logic        so_valid,
    input  logic        cfg_msb,
    input  logic [1:0]  cfg_length,
    input  logic        word_ready,
    output logic [31:0] word_data,
    output logic [5:0]  word_len,
    output logic        word_err,
    output logic        word_valid,
    output logic        overflow,
    output logic [7:0]  frame_cnt
);

    typedef enum logic {IDLE, RECV} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  len;
        logic        err;
    } entry_t;

    state_t      state, next_state;
    logic [31:0] shreg;
    logic [5:0]  bit_cnt;
    logic        msb_q;
    logic [1:0]  len_q;

    logic        push, pop, push_ok, full;
    logic [5:0]  exp_len;
    entry_t      new_entry;
    entry_t      mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // values from before the edge; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        unique case (state)
            IDLE: if (so_valid) next_state = RECV;
            RECV: if (!so_valid) begin
                next_state = IDLE;
                push       = 1'b1;   // frame end: this cycle's so_valid=0
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- Bit capture ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
            msb_q   <= 1'b0;
            len_q   <= 2'b00;
        end else if (state == IDLE) begin
            if (so_valid) begin
                // First bit lands in bit 0 for either bit order.
                shreg   <= {31'b0, so_data};
                bit_cnt <= 6'd1;
                msb_q   <= cfg_msb;
                len_q   <= cfg_length;
            end
        end else if (so_valid) begin
            if (bit_cnt < 6'd32) begin
                if (msb_q) shreg <= {shreg[30:0], so_data};
                else       shreg[bit_cnt[4:0]] <= so_data;
                bit_cnt <= bit_cnt + 6'd1;
            end else begin
                // Bits past 32 are dropped; count saturates at 33 to flag it.
                bit_cnt <= 6'd33;
            end
        end
    end

    // Expected length is 8 * (cfg_length + 1); 3-bit sum covers 1..4.
    assign exp_len   = {({1'b0, len_q} + 3'd1), 3'b000};
    assign new_entry = '{data: shreg, len: bit_cnt, err: (bit_cnt != exp_len)};

    // ---------------- 2-entry FIFO ----------------
    assign full       = (count == 2'd2);
    assign word_valid = (count != 2'd0);
    assign pop        = word_valid & word_ready;
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign push_ok    = push & (~full | pop);

    // NOTE: storage is not reset; outputs are gated by word_valid, so stale
    // contents are never visible and the array maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            overflow  <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            if (push_ok) begin
                wr_ptr    <= ~wr_ptr;
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (push_ok && !pop)      count <= count + 2'd1;
            else if (!push_ok && pop) count <= count - 2'd1;
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    always_comb begin
        word_data = '0;
        word_len  = '0;
        word_err  = 1'b0;
        if (word_valid) begin
            word_data = mem[rd_ptr].data;
            word_len  = mem[rd_ptr].len;
            word_err  = mem[rd_ptr].err;
        end
    end

endmodule

// File: tb/tb_sti_rx_pack.sv
// Directed testbench for sti_rx_pack. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_sti_rx_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        so_data, so_valid, cfg_msb, word_ready;
    logic [1:0]  cfg_length;
    logic [31:0] word_data;
    logic [5:0]  word_len;
    logic        word_err, word_valid, overflow;
    logic [7:0]  frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sti_rx_pack dut (
        .clk        (clk),
        .reset      (reset),
        .so_data    (so_data),
        .so_valid   (so_valid),
        .cfg_msb    (cfg_msb),
        .cfg_length (cfg_length),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_len   (word_len),
        .word_err   (word_err),
        .word_valid (word_valid),
        .overflow   (overflow),
        .frame_cnt  (frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends n bits of val (MSB-first: val[n-1] down to val[0]; LSB-first:
    // val[0] upward), then drops so_valid for the frame-end cycle. word_ready
    // is driven to ready_at_end during that frame-end cycle.
    task automatic send_frame(input logic msb, input logic [1:0] len,
                              input logic [63:0] val, input int n,
                              input logic ready_at_end);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            so_valid   = 1'b1;
            cfg_msb    = msb;
            cfg_length = len;
            so_data    = msb ? val[n-1-i] : val[i];
        end
        @(negedge clk);
        so_valid   = 1'b0;
        so_data    = 1'b0;
        word_ready = ready_at_end;
    endtask

    // Accept the head word for exactly one cycle.
    task automatic pop_one();
        @(negedge clk);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] d,
                              input logic [5:0] l, input logic e);
        check({tag, ".valid"}, {31'b0, word_valid}, 32'd1);
        check({tag, ".data"},  word_data, d);
        check({tag, ".len"},   {26'b0, word_len}, {26'b0, l});
        check({tag, ".err"},   {31'b0, word_err}, {31'b0, e});
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, {31'b0, word_valid}, 32'd0);
        check({tag, ".data"},  word_data, 32'd0);
        check({tag, ".len"},   {26'b0, word_len}, 32'd0);
        check({tag, ".err"},   {31'b0, word_err}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; so_data = 1'b0; so_valid = 1'b0;
        cfg_msb = 1'b0; cfg_length = 2'b00; word_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_empty("rst");
        check("rst.ovf", {31'b0, overflow}, 32'd0);
        check("rst.cnt", {24'b0, frame_cnt}, 32'd0);
        reset = 1'b1;

        // 8-bit MSB-first 1,0,1,1,0,0,1,0 -> 0xB2
        send_frame(1'b1, 2'b00, 64'hB2, 8, 1'b0);
        @(negedge clk);
        check_head("msb8", 32'h0000_00B2, 6'd8, 1'b0);
        check("msb8.cnt", {24'b0, frame_cnt}, 32'd1);
        pop_one();
        check_empty("msb8.pop");

        // 16-bit LSB-first 0xA5C3
        send_frame(1'b0, 2'b01, 64'hA5C3, 16, 1'b0);
        @(negedge clk);
        check_head("lsb16", 32'h0000_A5C3, 6'd16, 1'b0);
        check("lsb16.cnt", {24'b0, frame_cnt}, 32'd2);
        pop_one();

        // 35 ones, 32-bit expected -> saturated length 33, error
        send_frame(1'b1, 2'b11, 64'h7_FFFF_FFFF, 35, 1'b0);
        @(negedge clk);
        check_head("long", 32'hFFFF_FFFF, 6'd33, 1'b1);
        check("long.cnt", {24'b0, frame_cnt}, 32'd3);
        pop_one();

        // Short frame: 4 bits 1,0,1,1 against 8 expected -> error, still pushed
        send_frame(1'b1, 2'b00, 64'hB, 4, 1'b0);
        @(negedge clk);
        check_head("short", 32'h0000_000B, 6'd4, 1'b1);
        check("short.cnt", {24'b0, frame_cnt}, 32'd4);
        pop_one();
        check_empty("short.pop");

        // Three back-to-back frames with one idle cycle, no reader -> third dropped
        send_frame(1'b1, 2'b00, 64'h11, 8, 1'b0);
        send_frame(1'b1, 2'b00, 64'h22, 8, 1'b0);
        send_frame(1'b1, 2'b00, 64'h33, 8, 1'b0);
        @(negedge clk);
        check_head("ovf.h0", 32'h11, 6'd8, 1'b0);
        check("ovf.flag", {31'b0, overflow}, 32'd1);
        check("ovf.cnt", {24'b0, frame_cnt}, 32'd6);
        pop_one();
        check_head("ovf.h1", 32'h22, 6'd8, 1'b0);
        pop_one();
        check_empty("ovf.end");
        check("ovf.sticky", {31'b0, overflow}, 32'd1);

        // Reset after 5 bits of a frame; partial frame must vanish
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            so_valid = 1'b1; cfg_msb = 1'b1; cfg_length = 2'b00; so_data = i[0];
        end
        @(negedge clk);
        reset = 1'b0; so_valid = 1'b0; so_data = 1'b0;
        #1;
        check("mid.rst.ovf", {31'b0, overflow}, 32'd0);
        check("mid.rst.cnt", {24'b0, frame_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_empty("mid.rel");
        send_frame(1'b1, 2'b00, 64'h5A, 8, 1'b0);
        @(negedge clk);
        check_head("mid.5a", 32'h5A, 6'd8, 1'b0);
        check("mid.cnt", {24'b0, frame_cnt}, 32'd1);
        pop_one();
        check_empty("mid.pop");

        // Full FIFO, third frame ends in the same cycle as a pop
        send_frame(1'b1, 2'b00, 64'hA1, 8, 1'b0);
        send_frame(1'b1, 2'b00, 64'hB2, 8, 1'b0);
        send_frame(1'b1, 2'b00, 64'hC3, 8, 1'b1);
        @(negedge clk);
        word_ready = 1'b0;
        check("same.ovf", {31'b0, overflow}, 32'd0);
        check("same.cnt", {24'b0, frame_cnt}, 32'd4);
        check_head("same.h0", 32'hB2, 6'd8, 1'b0);
        pop_one();
        check_head("same.h1", 32'hC3, 6'd8, 1'b0);
        pop_one();
        check_empty("same.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sti_rx_pack.md
STI_RX_PACK -- requirements
Module: sti_rx_pack

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
REQ-003 SHALL have port so_data  input  1  serial data bit from the upstream serial transmitter.
REQ-004 SHALL have port so_valid  input  1  high while so_data carries a frame bit; one bit per cycle.
REQ-005 SHALL have port cfg_msb  input  1  1 = frame arrives MSB-first, 0 = LSB-first.
REQ-006 SHALL have port cfg_length  input  2  expected frame length: 00=8, 01=16, 10=24, 11=32 bits.
REQ-007 SHALL have port word_ready  input  1  downstream accepts the head word when high together with word_valid.
REQ-008 SHALL have port word_data  output  32  reassembled word, right-justified, zero-extended above received length.
REQ-009 SHALL have port word_len  output  6  number of bits received for the head word (1..32; 33 marks overlength).
REQ-010 SHALL have port word_err  output  1  head word length did not equal the expected length.
REQ-011 SHALL have port word_valid  output  1  FIFO holds at least one word.
REQ-012 SHALL have port overflow  output  1  sticky; a completed frame was dropped because the FIFO was full.
REQ-013 SHALL have port frame_cnt  output  8  count of frames pushed into the FIFO, wraps 255->0.

Function
REQ-014 SHALL implement FSM with states IDLE and RECV; reset state IDLE.
REQ-015 IDLE->RECV SHALL occur on the first cycle so_valid=1; that cycle's so_data is bit 0 of the frame; cfg_msb and cfg_length SHALL be captured that same cycle and held for the frame.
REQ-016 RECV SHALL stay while so_valid=1, capturing one bit per cycle; RECV->IDLE on the first cycle so_valid=0 (frame end).
REQ-017 MSB-first: shift register SHALL shift left one place and insert so_data at bit 0 each captured bit.
REQ-018 LSB-first: so_data SHALL be written to bit position bit_cnt (bit_cnt = bits already captured in the frame).
REQ-019 bit_cnt SHALL be 6 bits, cleared at frame start, increment per captured bit, saturate at 33; bits beyond 32 SHALL be discarded without altering the shift register.
REQ-020 At frame end SHALL push {data, bit_cnt, err} into a 2-entry FIFO, err = (bit_cnt != 8*(captured cfg_length+1)).
REQ-021 Push SHALL be visible as word_valid=1 on the cycle after frame end when the FIFO was empty.
REQ-022 Pop SHALL occur on any cycle with word_valid=1 and word_ready=1; word_data/word_len/word_err SHALL present the next entry the following cycle.
REQ-023 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; no drop, no overflow.
REQ-024 Push to a full FIFO without simultaneous pop SHALL drop the frame, set overflow, and leave frame_cnt unchanged.
REQ-025 frame_cnt SHALL increment on every successful push, including err frames.
REQ-026 A frame ending with so_valid=0 for exactly one cycle followed by so_valid=1 SHALL be pushed, and the next frame SHALL start on the so_valid=1 cycle (back-to-back, no bit lost).
REQ-027 When word_valid=0, word_data, word_len, word_err SHALL be 0.

Reset
REQ-028 reset low SHALL force: state IDLE, bit_cnt 0, shift register 0, FIFO empty, word_valid 0, word_data 0, word_len 0, word_err 0, overflow 0, frame_cnt 0.
REQ-029 reset asserted mid-frame SHALL discard the partial frame; no push on reset release.
REQ-030 overflow SHALL clear only by reset.

Verification
REQ-031 cfg_msb=1, cfg_length=00, serial 1,0,1,1,0,0,1,0 then so_valid=0 -> next cycle word_valid=1, word_data=0x000000B2, word_len=8, word_err=0, frame_cnt=1.
REQ-032 cfg_msb=0, cfg_length=01, 16 bits of 0xA5C3 sent LSB-first -> word_data=0x0000A5C3, word_len=16, word_err=0.
REQ-033 cfg_length=11, 35 bits of 1 sent MSB-first -> word_data=0xFFFFFFFF, word_len=33, word_err=1.
REQ-034 word_ready=0, three 8-bit frames 0x11,0x22,0x33 -> FIFO holds 0x11,0x22; overflow=1; frame_cnt=2; then word_ready=1 -> pops 0x11 then 0x22, word_valid=0 after.
REQ-035 FIFO full, frame end in same cycle as pop -> no overflow, frame_cnt increments, order preserved.
REQ-036 reset low after 5 bits of a frame, release, send full 8-bit frame 0x5A MSB-first -> single word 0x5A, frame_cnt=1, no error.
